// File: rtl/xor_64_bit_unit.sv
// -----------------------------------------------------------------------------
// xor_64_bit_unit
//
// Logic-op slice of the execute stage: bitwise XOR of two operands.
// xor_ab is the zero-latency result for use inside the stage. xor_q is a
// one-cycle registered copy for the stage boundary. The zero and parity flags
// are derived from the same registered value.
//
// Ports
//   clk        system clock, rising-edge active
//   rst        synchronous active-high reset
//   a, b       operands (WIDTH bits)
//   in_valid   operands valid; capture enable for the registered outputs
//   xor_ab     combinational a ^ b
//   xor_q      registered a ^ b, held while in_valid is low
//   out_valid  high for one cycle after each capture
//   zero_q     captured result was all zeros
//   parity_q   XOR-reduction (odd parity) of the captured result
// -----------------------------------------------------------------------------
module xor_64_bit_unit #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  output logic [WIDTH-1:0] xor_ab,
  output logic [WIDTH-1:0] xor_q,
  output logic             out_valid,
  output logic             zero_q,
  output logic             parity_q
);

  assign xor_ab = a ^ b;

  // The flags are computed from xor_ab in the same cycle as xor_q is loaded.
  // This means they can never describe a different operand pair than xor_q.
  logic zero_d;
  logic parity_d;

  assign zero_d   = (xor_ab == '0);
  assign parity_d = ^xor_ab;

  always_ff @(posedge clk) begin
    if (rst) begin
      xor_q     <= '0;
      out_valid <= 1'b0;
      zero_q    <= 1'b0;
      parity_q  <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        xor_q    <= xor_ab;
        zero_q   <= zero_d;
        parity_q <= parity_d;
      end
    end
  end

endmodule

// File: tb/tb_xor_64_bit_unit.sv
module tb_xor_64_bit_unit;

  logic        clk;
  logic        rst;
  logic [63:0] a;
  logic [63:0] b;
  logic        in_valid;
  logic [63:0] xor_ab;
  logic [63:0] xor_q;
  logic        out_valid;
  logic        zero_q;
  logic        parity_q;

  int n_checks;
  int n_fail;

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  xor_64_bit_unit #(.WIDTH(64)) dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .b         (b),
    .in_valid  (in_valid),
    .xor_ab    (xor_ab),
    .xor_q     (xor_q),
    .out_valid (out_valid),
    .zero_q    (zero_q),
    .parity_q  (parity_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic comb(input string tag, input logic [63:0] va, input logic [63:0] vb,
                      input logic [63:0] exp);
    a = va;
    b = vb;
    #1;
    chk(tag, xor_ab, exp);
  endtask

  task automatic capture(input logic [63:0] va, input logic [63:0] vb);
    a        = va;
    b        = vb;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
    tick();
    tick();

    chk("rst_xor_q",     xor_q, 64'h0);
    chk("rst_out_valid", {63'h0, out_valid}, 64'h0);
    chk("rst_zero_q",    {63'h0, zero_q}, 64'h0);
    chk("rst_parity_q",  {63'h0, parity_q}, 64'h0);

    rst = 1'b0;

    comb("comb_zero",   64'h0, 64'h0, 64'h0);
    comb("comb_ones",   ONES, 64'h0, ONES);
    comb("comb_self",   ONES, ONES, 64'h0);
    comb("comb_msb",    64'h8000_0000_0000_0000, 64'h0, 64'h8000_0000_0000_0000);
    comb("comb_lsb",    64'h1, 64'h0, 64'h1);
    comb("pat_aa55",    64'hAA55_AA55_AA55_AA55, 64'h55AA_55AA_55AA_55AA, ONES);
    comb("pat_aa_55",   64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, ONES);
    comb("pat_ffff",    64'hFFFF_0000_FFFF_0000, 64'h0000_FFFF_0000_FFFF, ONES);
    comb("pat_inv",     64'hFFFF_FFFF_0000_0000, 64'h0000_0000_FFFF_FFFF, ONES);
    comb("ident_a0",    64'h1234_5678_9ABC_DEF0, 64'h0, 64'h1234_5678_9ABC_DEF0);
    comb("ident_aa",    64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 64'h0);
    chk("comb_no_capture_ov", {63'h0, out_valid}, 64'h0);
    tick();
    chk("comb_no_capture_q", xor_q, 64'h0);

    capture(64'h1234_5678_9ABC_DEF0, 64'hFEDC_BA98_7654_3210);
    chk("reg_xor_q",     xor_q, 64'hECE8_ECE0_ECE8_ECE0);
    chk("reg_zero_q",    {63'h0, zero_q}, 64'h0);
    chk("reg_parity_q",  {63'h0, parity_q}, 64'h0);
    chk("reg_out_valid", {63'h0, out_valid}, 64'h1);
    a = ONES;
    b = 64'h0;
    tick();
    chk("hold_out_valid", {63'h0, out_valid}, 64'h0);
    chk("hold_xor_q",     xor_q, 64'hECE8_ECE0_ECE8_ECE0);

    capture(64'h7FFF_FFFF_FFFF_FFFF, ONES);
    chk("msb_xor_q",    xor_q, 64'h8000_0000_0000_0000);
    chk("msb_parity_q", {63'h0, parity_q}, 64'h1);
    chk("msb_zero_q",   {63'h0, zero_q}, 64'h0);
    tick();
    chk("msb_hold_parity", {63'h0, parity_q}, 64'h1);

    capture(ONES, ONES);
    chk("zero_xor_q",    xor_q, 64'h0);
    chk("zero_zero_q",   {63'h0, zero_q}, 64'h1);
    chk("zero_parity_q", {63'h0, parity_q}, 64'h0);
    tick();
    chk("zero_hold_zero", {63'h0, zero_q}, 64'h1);

    a        = 64'h0;
    b        = 64'hDEAD_BEEF_DEAD_BEEF;
    in_valid = 1'b1;
    tick();
    chk("b2b_0_xor_q",  xor_q, 64'hDEAD_BEEF_DEAD_BEEF);
    chk("b2b_0_ov",     {63'h0, out_valid}, 64'h1);
    chk("b2b_0_parity", {63'h0, parity_q}, 64'h0);
    a = 64'h1;
    b = 64'h0;
    tick();
    chk("b2b_1_xor_q",  xor_q, 64'h1);
    chk("b2b_1_ov",     {63'h0, out_valid}, 64'h1);
    chk("b2b_1_parity", {63'h0, parity_q}, 64'h1);
    chk("b2b_1_zero",   {63'h0, zero_q}, 64'h0);

    a        = ONES;
    b        = 64'h0;
    in_valid = 1'b1;
    rst      = 1'b1;
    #1;
    chk("rstp_comb_before", xor_ab, ONES);
    tick();
    chk("rstp_xor_q",     xor_q, 64'h0);
    chk("rstp_out_valid", {63'h0, out_valid}, 64'h0);
    chk("rstp_zero_q",    {63'h0, zero_q}, 64'h0);
    chk("rstp_parity_q",  {63'h0, parity_q}, 64'h0);
    chk("rstp_comb_after", xor_ab, ONES);

    rst = 1'b0;
    a   = 64'h8000_0000_0000_0001;
    b   = 64'h0;
    tick();
    in_valid = 1'b0;
    chk("post_rst_xor_q",  xor_q, 64'h8000_0000_0000_0001);
    chk("post_rst_ov",     {63'h0, out_valid}, 64'h1);
    chk("post_rst_parity", {63'h0, parity_q}, 64'h0);
    chk("post_rst_zero",   {63'h0, zero_q}, 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/xor_64_bit_unit.md
Name: xor_64_bit_unit

Overview:
- 64-bit bitwise XOR datapath block used as the logic-op slice of the sequential processor's execute stage.
- Provides a zero-latency combinational result for in-stage use.
- Also provides a one-cycle registered copy of the result with valid, zero and parity flags for the stage boundary.

Parameters:
- WIDTH, 64, operand/result width in bits; all behaviour below is specified at the default value.

Ports:
- clk  input  1  system clock; all registers update on the rising edge.
- rst  input  1  synchronous active-high reset.
- a  input  64  operand A.
- b  input  64  operand B.
- in_valid  input  1  operands valid this cycle; capture enable for the registered outputs.
- xor_ab  output  64  combinational result a ^ b.
- xor_q  output  64  registered result.
- out_valid  output  1  xor_q and flags hold a freshly captured result.
- zero_q  output  1  registered flag: captured result equals 0.
- parity_q  output  1  registered flag: XOR-reduction (odd parity) of the captured result.

Behaviour:
- xor_ab[i] = a[i] ^ b[i] for i = 0..63.
  - Purely combinational, no clock or reset dependence, no carries or cross-bit interaction.
  - Valid within the same cycle the inputs change.
- Reset is synchronous and active-high: on a rising clk edge with rst=1, xor_q=0, out_valid=0, zero_q=0, parity_q=0.
  - rst has priority over in_valid.
  - xor_ab is unaffected by reset.
- Capture: on a rising edge with rst=0 and in_valid=1:
  - xor_q <= a ^ b
  - zero_q <= (a ^ b == 0)
  - parity_q <= ^(a ^ b)
  - out_valid <= 1
- Hold: on a rising edge with rst=0 and in_valid=0, xor_q, zero_q and parity_q hold their values and out_valid <= 0.
- Latency: registered outputs appear 1 cycle after capture. Back-to-back in_valid gives one result per cycle (throughput 1/cycle, no stall, no backpressure).
- All flags derive from the same captured value as xor_q and never mix operands from different cycles.
- Reset asserted mid-stream discards the pending result. The first capture after rst deasserts behaves as normal.
- Boundary identities that must hold bit-exactly:
  - a ^ a = 0
  - a ^ 0 = a
  - a ^ ~a = all ones
  - MSB (bit 63) and LSB (bit 0) are handled identically to all other bits.

Test Plan:
- Comb sweep with in_valid=0:
  - a=0, b=0 -> xor_ab=0.
  - a=FFFFFFFFFFFFFFFF, b=0 -> FFFFFFFFFFFFFFFF.
  - a=b=FFFFFFFFFFFFFFFF -> 0.
  - a=8000000000000000, b=0 -> 8000000000000000.
  - a=1, b=0 -> 1.
- Pattern cases:
  - AA55AA55AA55AA55 ^ 55AA55AA55AA55AA -> FFFFFFFFFFFFFFFF.
  - AAAAAAAAAAAAAAAA ^ 5555555555555555 -> FFFFFFFFFFFFFFFF.
  - FFFF0000FFFF0000 ^ 0000FFFF0000FFFF -> FFFFFFFFFFFFFFFF.
  - a=FFFFFFFF00000000, b=~a -> FFFFFFFFFFFFFFFF.
- Registered path:
  - a=123456789ABCDEF0, b=FEDCBA9876543210, in_valid=1 for one edge -> next cycle xor_q=ECE8ECE0ECE8ECE0, zero_q=0, parity_q=0, out_valid=1.
  - Following cycle with in_valid=0 -> out_valid=0, xor_q held.
- Flags:
  - a=7FFFFFFFFFFFFFFF, b=FFFFFFFFFFFFFFFF captured -> xor_q=8000000000000000, parity_q=1, zero_q=0.
  - a=b=FFFFFFFFFFFFFFFF captured -> xor_q=0, zero_q=1, parity_q=0.
- Back-to-back:
  - Capture a=0, b=DEADBEEFDEADBEEF, then 1^0, on consecutive edges -> xor_q=DEADBEEFDEADBEEF, then 1, with out_valid=1 both cycles.
- Reset priority:
  - rst=1 with in_valid=1 and a=FFFFFFFFFFFFFFFF, b=0 -> after the edge xor_q=0, out_valid=0, zero_q=0, parity_q=0, while xor_ab=FFFFFFFFFFFFFFFF throughout.
